// File: rtl/rv32i_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_cpu_core
//  Description : Single-cycle RV32I integer core. One instruction per clock,
//                combinational instruction fetch, byte-masked word-aligned
//                data port with asynchronous read and clocked write.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_cpu_core (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_debug
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alt_op;
    logic        alu_valid;
    logic        branch_taken;
    logic [31:0] ea;
    logic [1:0]  lane;
    logic [31:0] jalr_sum;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        load_valid;

    logic        rd_we;
    logic [31:0] rd_data;
    logic        store_en;
    logic [3:0]  store_mask;
    logic [31:0] store_data;

    // Instruction field extraction
    assign opcode = imem_rdata[6:0];
    assign rd     = imem_rdata[11:7];
    assign funct3 = imem_rdata[14:12];
    assign rs1    = imem_rdata[19:15];
    assign rs2    = imem_rdata[24:20];
    assign funct7 = imem_rdata[31:25];

    assign imm_i = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
    assign imm_s = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
    assign imm_b = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign imm_u = {imem_rdata[31:12], 12'd0};
    assign imm_j = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};

    // x0 is hardwired to zero on both read ports
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign pc_plus4 = pc + 32'd4;
    assign jalr_sum = rs1_val + imm_i;
    assign ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign lane     = ea[1:0];

    // Register-register ops use rs2; immediate ops use imm_i (shamt in [4:0])
    assign alu_b  = (opcode == OP_REG) ? rs2_val : imm_i;
    assign alt_op = funct7[5];

    // ALU result and encoding validity (funct7 must be 0, or 0x20 on SUB/SRA/SRAI)
    always_comb begin
        alu_out   = 32'd0;
        alu_valid = 1'b1;
        case (funct3)
            3'b000: alu_out = (opcode == OP_REG && alt_op) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alt_op ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                     : rs1_val >> alu_b[4:0];
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
        if (opcode == OP_REG) begin
            alu_valid = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (funct3 == 3'b001) begin
            alu_valid = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
            alu_valid = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
    end

    // Branch condition evaluation
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Lane extraction and sign/zero extension of load data
    always_comb begin
        case (lane)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half  = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_valid = 1'b1;
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: begin
                load_data  = mem_rdata;
                load_valid = 1'b0;
            end
        endcase
    end

    // Next PC, register writeback and store lane selection
    always_comb begin
        next_pc    = pc_plus4;
        rd_we      = 1'b0;
        rd_data    = alu_out;
        store_en   = 1'b0;
        store_mask = 4'b0000;
        store_data = rs2_val;
        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = jalr_sum & ~32'd1;
            end
            OP_BRANCH: begin
                if (branch_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                rd_we   = load_valid;
                rd_data = load_data;
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        store_en   = 1'b1;
                        store_mask = 4'b0001 << lane;
                        store_data = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        store_en   = 1'b1;
                        store_mask = lane[1] ? 4'b1100 : 4'b0011;
                        store_data = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        store_en   = 1'b1;
                        store_mask = 4'b1111;
                    end
                    default: store_en = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: rd_we = alu_valid;
            default: rd_we = 1'b0;
        endcase
    end

    // Program counter; reset restarts fetch at address 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    // Register file write port; writes to x0 are discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (rd_we && rd != 5'd0) begin
            regs[rd] <= rd_data;
        end
    end

    // Memory port is forced idle while reset is held so an aborted store never commits
    assign imem_addr = pc;
    assign pc_debug  = pc;
    assign mem_we    = reset & store_en;
    assign mem_wmask = reset ? store_mask : 4'b0000;
    assign mem_addr  = reset ? {ea[31:2], 2'b00} : 32'd0;
    assign mem_wdata = reset ? store_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_cpu_core
//  Description : Self-checking bench for rv32i_cpu_core: directed trace table,
//                reset-abort sequence and random programs against an ISA model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_cpu_core;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] pc_debug;

    logic [31:0] imem [256];
    logic [31:0] dmem [2048];
    logic        fill_mem;

    int n_vec;
    int n_err;

    // Reference model state
    logic [31:0] mpc;
    logic [31:0] mx   [32];
    logic [31:0] mmem [2048];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl [$];

    rv32i_cpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata),
        .pc_debug   (pc_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[9:2]];
    assign mem_rdata  = dmem[mem_addr[12:2]];

    // Data memory: clocked byte-masked write
    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 2048; i++) dmem[i] <= $urandom;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) dmem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                                input logic [31:0] addr, input logic [3:0] mask,
                                input logic [31:0] wdata);
        vec_t v;
        v.pc = pc; v.ins = ins; v.we = we; v.addr = addr; v.mask = mask; v.wdata = wdata;
        return v;
    endfunction

    // ---------------- random instruction generator ----------------
    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [31:0] imm;
        logic [2:0]  f3;
        int          k;
        int          off;
        rd  = 5'($urandom_range(0, 15));
        r1  = 5'($urandom_range(0, 15));
        r2  = 5'($urandom_range(0, 15));
        imm = $urandom;
        f3  = 3'($urandom_range(0, 7));
        k   = int'($urandom_range(0, 99));
        if (k < 22) begin
            if (f3 == 3'd1) imm = {27'd0, imm[4:0]};
            else if (f3 == 3'd5) imm = {20'd0, (imm[10] ? 7'h20 : 7'h00), imm[4:0]};
            return enc_i(imm, r1, f3, rd, 7'h13);
        end else if (k < 38) begin
            return enc_r(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00, r2, r1, f3, rd);
        end else if (k < 44) begin
            return enc_u(imm, rd, imm[20] ? 7'h37 : 7'h17);
        end else if (k < 56) begin
            if (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'd2;
            return enc_i(imm, r1, f3, rd, 7'h03);
        end else if (k < 74) begin
            return enc_s(imm, r2, r1, 3'($urandom_range(0, 2)));
        end else if (k < 86) begin
            if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
            off = (int'($urandom_range(0, 11)) - 6) * 4;
            if (off == 0) off = 8;
            return enc_b(32'(off), r2, r1, f3);
        end else if (k < 91) begin
            off = (int'($urandom_range(0, 15)) - 5) * 4;
            if (off == 0) off = 12;
            return enc_j(32'(off), rd);
        end else if (k < 95) begin
            return enc_i(imm, r1, 3'd0, rd, 7'h67);
        end else if (k < 97) begin
            return 32'h0000_000F;
        end else if (k < 99) begin
            return 32'h0000_0073;
        end
        return {imm[31:7], 7'h7F};
    endfunction

    // ---------------- ISA reference model ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        longint s;
        s = longint'(v);
        if (v[bits-1]) s = s - (longint'(1) << bits);
        return 32'(s);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(b[4:0]);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sa;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> sa) | (a[31] ? ~(32'hFFFF_FFFF >> sa) : 32'd0)) : a >> sa;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(output logic e_we, output logic [31:0] e_addr,
                              output logic [3:0] e_mask, output logic [31:0] e_wdata);
        logic [31:0] ins, a, b, ii, si, bi, ui, ji, ea, res, word, npc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr;
        int          sh;
        ins = imem[mpc[9:2]];
        a   = mx[ins[19:15]];
        b   = mx[ins[24:20]];
        ii  = sext({20'd0, ins[31:20]}, 12);
        si  = sext({20'd0, ins[31:25], ins[11:7]}, 12);
        bi  = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        ui  = {ins[31:12], 12'd0};
        ji  = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        rd  = ins[11:7];
        f3  = ins[14:12];
        npc = mpc + 32'd4;
        wr = 1'b0; res = 32'd0;
        e_we = 1'b0; e_addr = 32'd0; e_mask = 4'd0; e_wdata = 32'd0;
        case (ins[6:0])
            7'h37: begin wr = 1'b1; res = ui; end
            7'h17: begin wr = 1'b1; res = mpc + ui; end
            7'h6F: begin wr = 1'b1; res = mpc + 32'd4; npc = mpc + ji; end
            7'h67: begin wr = 1'b1; res = mpc + 32'd4; npc = (a + ii) & ~32'd1; end
            7'h63: if (ref_taken(f3, a, b)) npc = mpc + bi;
            7'h03: begin
                ea   = a + ii;
                word = mmem[ea[12:2]];
                sh   = 8 * int'(ea[1:0]);
                wr   = 1'b1;
                case (f3)
                    3'd0: res = sext((word >> sh) & 32'hFF, 8);
                    3'd1: res = sext(ea[1] ? word >> 16 : word & 32'hFFFF, 16);
                    3'd2: res = word;
                    3'd4: res = (word >> sh) & 32'hFF;
                    3'd5: res = ea[1] ? word >> 16 : word & 32'hFFFF;
                    default: wr = 1'b0;
                endcase
            end
            7'h23: begin
                ea     = a + si;
                e_addr = ea & ~32'd3;
                case (f3)
                    3'd0: begin e_mask = 4'(1 << ea[1:0]); e_wdata = {4{b[7:0]}}; end
                    3'd1: begin e_mask = ea[1] ? 4'b1100 : 4'b0011; e_wdata = {2{b[15:0]}}; end
                    3'd2: begin e_mask = 4'b1111; e_wdata = b; end
                    default: e_mask = 4'd0;
                endcase
                e_we = (e_mask != 4'd0);
                for (int k = 0; k < 4; k++)
                    if (e_mask[k]) mmem[ea[12:2]][8*k +: 8] = e_wdata[8*k +: 8];
            end
            7'h13: begin wr = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
            7'h33: begin wr = 1'b1; res = ref_alu(f3, ins[30], a, b); end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 5'd0) mx[rd] = res;
        mpc = npc;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic        e_we;
        logic [31:0] e_addr, e_wdata, cur_pc;
        logic [3:0]  e_mask;
        n_vec = 0; n_err = 0;
        reset = 1'b0; fill_mem = 1'b1;

        // Directed execution trace: {pc, instruction, expected store port}
        tbl.push_back(mk(32'h00, enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h04, enc_i(32'hFFFF_FFF9, 5'd1, 3'd0, 5'd2, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h08, enc_s(32'd0, 5'd1, 5'd0, 3'd2), 1, 32'h0, 4'hF, 32'd5));
        tbl.push_back(mk(32'h0C, enc_s(32'd4, 5'd2, 5'd0, 3'd2), 1, 32'h4, 4'hF, 32'hFFFF_FFFE));
        tbl.push_back(mk(32'h10, enc_u(32'd1, 5'd3, 7'h37), 0, 0, 0, 0));
        tbl.push_back(mk(32'h14, enc_i(32'd1, 5'd0, 3'd0, 5'd4, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h18, enc_s(32'd0, 5'd4, 5'd3, 3'd2), 1, 32'h1000, 4'hF, 32'd1));
        tbl.push_back(mk(32'h1C, enc_i(32'h80, 5'd0, 3'd0, 5'd5, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h20, enc_s(32'd3, 5'd5, 5'd3, 3'd0), 1, 32'h1000, 4'b1000, 32'h8080_8080));
        tbl.push_back(mk(32'h24, enc_i(32'd3, 5'd3, 3'd0, 5'd7, 7'h03), 0, 0, 0, 0));
        tbl.push_back(mk(32'h28, enc_i(32'd3, 5'd3, 3'd4, 5'd8, 7'h03), 0, 0, 0, 0));
        tbl.push_back(mk(32'h2C, enc_s(32'd8, 5'd7, 5'd0, 3'd2), 1, 32'h8, 4'hF, 32'hFFFF_FF80));
        tbl.push_back(mk(32'h30, enc_s(32'd12, 5'd8, 5'd0, 3'd2), 1, 32'hC, 4'hF, 32'h0000_0080));
        tbl.push_back(mk(32'h34, enc_b(32'd8, 5'd1, 5'd2, 3'd4), 0, 0, 0, 0));
        tbl.push_back(mk(32'h3C, enc_b(32'd8, 5'd1, 5'd2, 3'd6), 0, 0, 0, 0));
        tbl.push_back(mk(32'h40, enc_i(32'h60, 5'd0, 3'd0, 5'd1, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h44, enc_i(32'd3, 5'd1, 3'd0, 5'd6, 7'h67), 0, 0, 0, 0));
        tbl.push_back(mk(32'h62, enc_s(32'd16, 5'd6, 5'd0, 3'd2), 1, 32'h10, 4'hF, 32'h48));
        tbl.push_back(mk(32'h66, enc_u(32'h80000, 5'd9, 7'h37), 0, 0, 0, 0));
        tbl.push_back(mk(32'h6A, enc_i(32'h404, 5'd9, 3'd5, 5'd10, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h6E, enc_i(32'd4, 5'd9, 3'd5, 5'd11, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h72, enc_i(32'd9, 5'd0, 3'd0, 5'd0, 7'h13), 0, 0, 0, 0));
        tbl.push_back(mk(32'h76, enc_s(32'd20, 5'd10, 5'd0, 3'd2), 1, 32'h14, 4'hF, 32'hF800_0000));
        tbl.push_back(mk(32'h7A, enc_s(32'd24, 5'd11, 5'd0, 3'd2), 1, 32'h18, 4'hF, 32'h0800_0000));
        tbl.push_back(mk(32'h7E, enc_s(32'd28, 5'd0, 5'd0, 3'd2), 1, 32'h1C, 4'hF, 32'h0));
        tbl.push_back(mk(32'h82, enc_s(32'd2, 5'd5, 5'd3, 3'd1), 1, 32'h1000, 4'b1100, 32'h0080_0080));
        tbl.push_back(mk(32'h86, enc_j(32'h7A, 5'd0), 0, 0, 0, 0));

        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        foreach (tbl[i]) imem[tbl[i].pc[9:2]] = tbl[i].ins;
        imem[32'h100 >> 2] = enc_s(32'd0, 5'd4, 5'd3, 3'd2);

        @(posedge clk); #1 fill_mem = 1'b0;
        @(negedge clk);
        check("reset_pc", pc_debug, 32'd0);
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_we", {31'd0, mem_we}, 32'd0);
        check("reset_mask", {28'd0, mem_wmask}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            check("trace_pc", pc_debug, tbl[i].pc);
            check("trace_we", {31'd0, mem_we}, {31'd0, tbl[i].we});
            check("trace_mask", {28'd0, mem_wmask}, {28'd0, tbl[i].mask});
            if (tbl[i].we) begin
                check("trace_addr", mem_addr, tbl[i].addr);
                check("trace_wdata", mem_wdata, tbl[i].wdata);
            end
            @(posedge clk); #1;
            if (tbl[i].we && tbl[i].mask == 4'hF)
                check("trace_commit", dmem[tbl[i].addr[12:2]], tbl[i].wdata);
        end

        // Reset pulled low in the middle of a SW: store must be dropped
        @(negedge clk);
        check("abort_pc", pc_debug, 32'h100);
        check("abort_we_before", {31'd0, mem_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_mask", {28'd0, mem_wmask}, 32'd0);
        check("abort_pc_now", pc_debug, 32'd0);
        @(posedge clk); #1;
        check("abort_tohost", dmem[32'h1000 >> 2], 32'h0080_0001);
        reset = 1'b1;
        @(negedge clk);
        check("restart_pc0", pc_debug, 32'd0);
        @(negedge clk);
        check("restart_pc4", pc_debug, 32'd4);

        // Random programs against the ISA model
        for (int p = 0; p < 6; p++) begin
            #1 reset = 1'b0;
            for (int i = 0; i < 256; i++) imem[i] = rand_instr();
            for (int i = 0; i < 2048; i++) mmem[i] = dmem[i];
            for (int i = 0; i < 32; i++) mx[i] = 32'd0;
            mpc = 32'd0;
            @(posedge clk); #1 reset = 1'b1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                cur_pc = mpc;
                model_step(e_we, e_addr, e_mask, e_wdata);
                check("rand_pc", pc_debug, cur_pc);
                check("rand_we", {31'd0, mem_we}, {31'd0, e_we});
                check("rand_mask", {28'd0, mem_wmask}, {28'd0, e_mask});
                if (e_we) begin
                    check("rand_addr", mem_addr, e_addr);
                    check("rand_wdata", mem_wdata, e_wdata);
                end
                @(posedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
